// File: rtl/pe_pkg.sv
// Shared helpers and default widths for the CNN processing element.
package pe_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Clamp v to the signed range of a w-bit value.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    localparam int PE_DATA_W = 8;
    localparam int PE_N_CELL = 9;
    localparam int PROD_W    = 2 * PE_DATA_W;
    localparam int TREE_W    = PROD_W + clog2(PE_N_CELL);

endpackage

// File: rtl/pe_adder_tree.sv
// Balanced signed adder tree: leaves padded to a power of two, summed as a heap.
module pe_adder_tree
    import pe_pkg::*;
#(
    parameter int N     = PE_N_CELL,
    parameter int IN_W  = PROD_W,
    parameter int OUT_W = TREE_W
) (
    input  logic [N-1:0][IN_W-1:0] in_i,
    output logic signed [OUT_W-1:0] sum_o
);
    localparam int L = 1 << clog2(N);

    logic signed [OUT_W-1:0] node [1:2*L-1];

    // Node i sums children 2i and 2i+1; leaves occupy L..2L-1.
    always_comb begin
        for (int i = 0; i < N; i++) node[L+i] = OUT_W'($signed(in_i[i]));
        for (int i = N; i < L; i++) node[L+i] = '0;
        for (int i = L - 1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
    end

    assign sum_o = node[1];

endmodule

// File: rtl/pe_mac_acc.sv
// Multi-beat MAC processing element with bias, round/shift/saturate and back-pressure.
// Define PE_RELU_EN to clamp negative results to zero.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int N_CELL  = 9,
    parameter int BIAS_W  = 16,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 8,
    parameter int STEP_W  = 3,
    parameter int SHIFT_W = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W*N_CELL-1:0]   in_data,
    input  logic [DATA_W*N_CELL-1:0]   in_weight,
    input  logic [BIAS_W-1:0]          bias,
    input  logic [STEP_W-1:0]          step,
    input  logic [SHIFT_W-1:0]         shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data
);
    localparam int PW = 2 * DATA_W;
    localparam int TW = PW + clog2(N_CELL);

    logic                      advance, take, first, last;
    logic [STEP_W-1:0]         cnt_q, step_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic [N_CELL-1:0][PW-1:0] prod_d, prod_q;
    logic                      s1_vld_q, s1_first_q, s1_last_q;
    logic [BIAS_W-1:0]         s1_bias_q;
    logic [SHIFT_W-1:0]        s1_shift_q;
    logic signed [TW-1:0]      tree_sum;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      sat_q, sat_d;
    logic                      out_vld_q;
    logic [OUT_W-1:0]          out_q, res_d;
    logic signed [63:0]        base64, sum64, sat64, rnd64, rsh64, o64;

    // One stall signal freezes both stages while a result waits downstream.
    assign advance   = !(out_vld_q && !out_ready);
    assign in_ready  = advance;
    assign take      = in_valid && advance;
    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == (first ? step : step_q));
    assign out_valid = out_vld_q;
    assign out_data  = out_q;

    for (genvar i = 0; i < N_CELL; i++) begin : g_lane
        logic signed [DATA_W-1:0] a, w;
        assign a         = in_data[(N_CELL-i)*DATA_W-1 -: DATA_W];
        assign w         = in_weight[(N_CELL-i)*DATA_W-1 -: DATA_W];
        assign prod_d[i] = PW'(a) * PW'(w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            step_q  <= '0;
            shift_q <= '0;
        end else if (take) begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (first) begin
                step_q  <= step;
                shift_q <= shift;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q   <= 1'b0;
            prod_q     <= '0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bias_q  <= '0;
            s1_shift_q <= '0;
        end else if (advance) begin
            s1_vld_q <= in_valid;
            if (take) begin
                prod_q     <= prod_d;
                s1_first_q <= first;
                s1_last_q  <= last;
                s1_bias_q  <= bias;
                s1_shift_q <= first ? shift : shift_q;
            end
        end
    end

    pe_adder_tree #(.N(N_CELL), .IN_W(PW), .OUT_W(TW)) u_tree (
        .in_i  (prod_q),
        .sum_o (tree_sum)
    );

    // Once the group has clipped, the accumulator stays pinned at the rail.
    always_comb begin
        base64 = s1_first_q ? 64'($signed(s1_bias_q)) : 64'(acc_q);
        sum64  = 64'(tree_sum) + base64;
        sat64  = sat_signed(sum64, ACC_W);
        if (!s1_first_q && sat_q) begin
            acc_d = acc_q;
            sat_d = 1'b1;
        end else begin
            acc_d = ACC_W'(sat64);
            sat_d = (sat64 != sum64);
        end
        rnd64 = (64'sd1 <<< s1_shift_q) >>> 1;
        rsh64 = (64'(acc_d) + rnd64) >>> s1_shift_q;
        o64   = sat_signed(rsh64, OUT_W);
`ifdef PE_RELU_EN
        if (o64 < 0) o64 = '0;
`endif
        res_d = OUT_W'(o64);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            sat_q     <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (advance && s1_vld_q) begin
                if (s1_last_q) begin
                    out_q <= res_d;
                    acc_q <= '0;
                    sat_q <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    sat_q <= sat_d;
                end
            end
            if (advance && s1_vld_q && s1_last_q) out_vld_q <= 1'b1;
            else if (out_ready)                   out_vld_q <= 1'b0;
        end
    end

endmodule

// File: doc/pe_mac_acc.md
# pe_mac_acc

Parametrised successor processing element for the CNN accelerator datapath. It multiplies N_CELL signed activation/weight pairs, reduces them through an adder tree, and accumulates across a programmable number of beats in a wide accumulator. Bias is added once per group. The result is rounded, shifted and saturated to the output width. It sits between the line-buffer/weight-fetch logic and the output writeback, and adds a valid/ready handshake with back-pressure.

## Interface
- DATA_W, 8, activation and weight element width (signed)
- N_CELL, 9, number of multiply lanes
- BIAS_W, 16, bias width (signed)
- ACC_W, 24, accumulator width (signed, saturating)
- OUT_W, 8, output width (signed)
- STEP_W, 3, width of beat-count field
- SHIFT_W, 3, width of right-shift field
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W*N_CELL  activations; lane 0 in the MSBs
- in_weight  in  DATA_W*N_CELL  weights; lane 0 in the MSBs
- bias  in  BIAS_W  group bias; sampled on the first beat of a group
- step  in  STEP_W  beats per group minus 1; sampled on the first beat
- shift  in  SHIFT_W  output right-shift; sampled on the first beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  saturated result

## Operation
- Beat accepted when in_valid && in_ready. in_ready = !(out_valid && !out_ready); the same signal advances both pipeline stages.
- Stage 1 registers the signed products of all N_CELL lanes, plus first/last flags, bias, shift, and a stage valid.
- Stage 2 sums the products; tree width is 2*DATA_W + clog2(N_CELL).
  - First beat: add the sign-extended bias.
  - Other beats: add the accumulator.
  - The result saturates to ACC_W.
- Beat counter: 0 on the first beat of a group; increments per accepted beat. The last beat is the one where counter == captured step. The counter then returns to 0.
- Gaps are allowed: with in_valid low, the counter and accumulator hold.
- step, bias and shift are captured on the first beat. Changes mid-group are ignored.
- Final value v:
  - if shift = s > 0: v = (acc + 2^(s-1)) >>> s (round half up, arithmetic);
  - s = 0: no rounding.
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- On the last beat, the result loads out_data, out_valid is set, and the accumulator clears.
- Accumulator saturation is sticky within a group: further beats cannot pull the value back inside range.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, counter=0, accumulator=0, stage valids=0.
- Latency: last beat accepted at edge E0 → out_valid high after E1 (2 cycles).
- Throughput: 1 beat/cycle when out_ready=1; step=0 gives one result per beat.
- Back-pressure:
  - while out_valid && !out_ready, out_data is stable and in_ready=0;
  - no beat is lost or duplicated.
- out_valid drops on the edge where out_ready=1, unless a new result loads on the same edge.
- Reset asserted mid-group: everything returns to reset values immediately. The partial group is discarded.

## Configuration
- PE_RELU_EN defined: after saturation, negative results are forced to 0 (out_data ∈ [0, 2^(OUT_W-1)-1]).
- Without it: full signed saturated output.

## Structure
- Shared package pe_pkg holds:
  - clog2 function;
  - sat_signed function (width-generic clamp);
  - localparams PROD_W and TREE_W.
- Sub-module pe_adder_tree: parametrised N-input signed balanced adder tree, purely combinational, width TREE_W.
- Top holds the multipliers, both pipeline stages, the counter, the accumulator, and the round/shift/saturate/ReLU logic.

## Test plan
- Defaults; all in=1, weight=2, bias=5, step=0, shift=0 → out_data=23 two cycles after accept.
- All in=127, weight=127, bias=0 → 145161, output clamps to 127. All in=-128, weight=127 → -128, or 0 with PE_RELU_EN.
- step=2, shift=1, bias=4, three beats all ones with idle gaps between them → (31+1)>>>1 = 16; one out_valid pulse.
- Negative rounding: sum -3, shift=1 → -1; sum -4, shift=2 → -1; sum 6, shift=2 → 2.
- Consecutive step=0 beats with out_ready low for 3 cycles:
  - in_ready low, out_data held;
  - after release, all results appear in order with no loss.
- Reset pulsed after beat 2 of a step=3 group → outputs at reset values; the next full group's result excludes the stale partial sum.
